fft_bin_collector: RTL and testbench

Receives the FFT core's Avalon-ST output stream (source_* signals) on CLK_50 and validates frame framing. It converts each complex bin to a block-exponent-normalised 16-bit magnitude and stores it in a double-buffered bin memory. Display and analysis logic read one complete, stable spectrum while the next frame is written.

---
 rtl/fft_rx_pkg.sv | 50 +++++
 rtl/fft_bin_ram.sv | 31 +++
 rtl/fft_bin_collector.sv | 188 ++++++++++++++++++
 tb/tb_fft_bin_collector.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_rx_pkg.sv
// rtl/fft_rx_pkg.sv - shared widths, collector state type and magnitude helpers
package fft_rx_pkg;

  localparam int DATA_W    = 24;
  localparam int MAG_W     = 16;
  localparam int MAG_RSH   = 9;   // scales a full-scale 24-bit magnitude into the 16-bit store
  localparam int MAX_SHIFT = 15;  // largest left shift applied for negative block exponents
  localparam int ABS_W     = DATA_W - 1;
  localparam int RAW_W     = DATA_W + 1;
  localparam int SCL_W     = RAW_W + MAX_SHIFT;

  typedef enum logic {IDLE = 1'b0, COLLECT = 1'b1} state_e;

  // |v| with the most negative code folded onto the largest positive one
  function automatic logic [ABS_W-1:0] abs_sat(input logic signed [DATA_W-1:0] v);
    logic signed [DATA_W-1:0] neg;
    neg = -v;
    if (v[DATA_W-1] && (v[ABS_W-1:0] == '0)) return {ABS_W{1'b1}};
    else if (v[DATA_W-1]) return neg[ABS_W-1:0];
    else return v[ABS_W-1:0];
  endfunction

  // alpha-max-plus-beta-min estimate: max + min/2
  function automatic logic [RAW_W-1:0] mag_approx(input logic [ABS_W-1:0] a,
                                                  input logic [ABS_W-1:0] b);
    logic [ABS_W-1:0] hi;
    logic [ABS_W-1:0] lo;
    hi = (a > b) ? a : b;
    lo = (a > b) ? b : a;
    return {2'b00, hi} + {3'b000, lo[ABS_W-1:1]};
  endfunction

  // negative block exponents undo the FFT's scaling, clamped to MAX_SHIFT
  function automatic logic [3:0] exp_shift(input logic signed [5:0] e);
    if (!e[5]) return 4'd0;
    else if (e < -6'sd15) return 4'(MAX_SHIFT);
    else return 4'(-e);
  endfunction

  // normalise and saturate into the stored magnitude width
  function automatic logic [MAG_W-1:0] scale_sat(input logic [RAW_W-1:0] m,
                                                 input logic [3:0] s);
    logic [SCL_W-1:0] w;
    w = {{MAX_SHIFT{1'b0}}, m} << s;
    w = w >> MAG_RSH;
    if (|w[SCL_W-1:MAG_W]) return {MAG_W{1'b1}};
    return w[MAG_W-1:0];
  endfunction

endpackage

// File: rtl/fft_bin_ram.sv
// rtl/fft_bin_ram.sv - two-bank magnitude store, one write port and one registered read port
module fft_bin_ram #(
  parameter int ADDR_W = 8,
  parameter int MAG_W  = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W:0]   wr_addr_i,
  input  logic [MAG_W-1:0]  wr_data_i,
  input  logic [ADDR_W:0]   rd_addr_i,
  output logic [MAG_W-1:0]  rd_data_o
);

  logic [MAG_W-1:0] mem_q [2**(ADDR_W+1)];
  logic [MAG_W-1:0] rd_data_q;

  // write port; the address MSB selects the bank and contents survive reset
  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  // registered read; only the output register is cleared by reset
  always_ff @(posedge clk_i) begin
    if (reset_i) rd_data_q <= '0;
    else         rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fft_bin_collector.sv
// rtl/fft_bin_collector.sv - frame checker and double-buffered magnitude collector for FFT output
module fft_bin_collector #(
  parameter int FFT_LEN = 256,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 24,
  parameter int MAG_W   = 16
) (
  input  logic              CLK_50,
  input  logic              reset,
  input  logic              source_valid,
  input  logic              source_sop,
  input  logic              source_eop,
  input  logic [1:0]        source_error,
  input  logic [DATA_W-1:0] source_real,
  input  logic [DATA_W-1:0] source_imag,
  input  logic [5:0]        source_exp,
  output logic              source_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [MAG_W-1:0]  rd_data,
  output logic              bank_sel,
  output logic              frame_done,
  output logic              frame_err,
  output logic [15:0]       frame_count
);
  import fft_rx_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FFT_LEN - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              bad_q, bad_d;
  logic [5:0]        exp_q, exp_d;
  logic              wbank_q, wbank_d;   // bank the next beat lands in; runs ahead of bank_sel by the pipeline depth
  logic              ready_q;

  logic              accept;
  logic              beat_wr, beat_commit, beat_len_err, beat_seq_err;
  logic [ADDR_W-1:0] beat_idx;
  logic [5:0]        beat_exp;

  logic              s1_vld_q, s1_commit_q, s1_len_err_q, s1_seq_err_q;
  logic [ABS_W-1:0]  s1_re_q, s1_im_q;
  logic [ADDR_W:0]   s1_addr_q;
  logic [5:0]        s1_exp_q;

  logic              s2_vld_q, s2_commit_q, s2_len_err_q;
  logic [ADDR_W:0]   s2_addr_q;
  logic [MAG_W-1:0]  s2_data_q;

  logic              bank_sel_q, frame_done_q, frame_err_q;
  logic [15:0]       frame_count_q;

  assign accept = source_valid & ready_q;

  // framing state machine: decides per beat whether and where it is written and the frame outcome
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    bad_d        = bad_q;
    exp_d        = exp_q;
    wbank_d      = wbank_q;
    beat_wr      = 1'b0;
    beat_idx     = idx_q;
    beat_exp     = exp_q;
    beat_commit  = 1'b0;
    beat_len_err = 1'b0;
    beat_seq_err = 1'b0;
    if (accept) begin
      if (source_sop) begin
        beat_seq_err = (state_q == COLLECT);
        beat_wr      = 1'b1;
        beat_idx     = '0;
        beat_exp     = source_exp;
        exp_d        = source_exp;
        bad_d        = |source_error;
        idx_d        = ADDR_W'(1);
        state_d      = COLLECT;
      end else if (state_q == COLLECT) begin
        beat_wr = 1'b1;
        bad_d   = bad_q | (|source_error);
        if (source_eop) begin
          state_d = IDLE;
          if ((idx_q == LAST_IDX) && !bad_d) begin
            beat_commit = 1'b1;
            wbank_d     = ~wbank_q;
          end else begin
            beat_len_err = 1'b1;
          end
        end else if (idx_q == LAST_IDX) begin
          beat_seq_err = 1'b1;
          state_d      = IDLE;
        end else begin
          idx_d = idx_q + ADDR_W'(1);
        end
      end
    end
  end

  // framing state and backpressure register
  always_ff @(posedge CLK_50) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      bad_q   <= 1'b0;
      exp_q   <= '0;
      wbank_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      bad_q   <= bad_d;
      exp_q   <= exp_d;
      wbank_q <= wbank_d;
      ready_q <= 1'b1;
    end
  end

  // stage 1: absolute values, target address with its bank, and exponent travel with the beat
  always_ff @(posedge CLK_50) begin
    if (reset) begin
      s1_vld_q     <= 1'b0;
      s1_commit_q  <= 1'b0;
      s1_len_err_q <= 1'b0;
      s1_seq_err_q <= 1'b0;
    end else begin
      s1_vld_q     <= beat_wr;
      s1_commit_q  <= beat_commit;
      s1_len_err_q <= beat_len_err;
      s1_seq_err_q <= beat_seq_err;
      s1_re_q      <= abs_sat(source_real);
      s1_im_q      <= abs_sat(source_imag);
      s1_addr_q    <= {wbank_q, beat_idx};
      s1_exp_q     <= beat_exp;
    end
  end

  // stage 2: magnitude estimate, exponent normalisation and saturation feeding the RAM write
  always_ff @(posedge CLK_50) begin
    if (reset) begin
      s2_vld_q     <= 1'b0;
      s2_commit_q  <= 1'b0;
      s2_len_err_q <= 1'b0;
    end else begin
      s2_vld_q     <= s1_vld_q;
      s2_commit_q  <= s1_commit_q;
      s2_len_err_q <= s1_len_err_q;
      s2_addr_q    <= s1_addr_q;
      s2_data_q    <= scale_sat(mag_approx(s1_re_q, s1_im_q), exp_shift(s1_exp_q));
    end
  end

  // frame outcome: commit lands on the same edge as the last bin write
  always_ff @(posedge CLK_50) begin
    if (reset) begin
      bank_sel_q    <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      frame_count_q <= '0;
    end else begin
      frame_done_q <= s2_commit_q;
      frame_err_q  <= s1_seq_err_q | s2_len_err_q;
      if (s2_commit_q) begin
        bank_sel_q    <= ~bank_sel_q;
        frame_count_q <= frame_count_q + 16'd1;
      end
    end
  end

  fft_bin_ram #(
    .ADDR_W (ADDR_W),
    .MAG_W  (MAG_W)
  ) u_ram (
    .clk_i     (CLK_50),
    .reset_i   (reset),
    .wr_en_i   (s2_vld_q),
    .wr_addr_i (s2_addr_q),
    .wr_data_i (s2_data_q),
    .rd_addr_i ({~bank_sel_q, rd_addr}),
    .rd_data_o (rd_data)
  );

  assign source_ready = ready_q;
  assign bank_sel     = bank_sel_q;
  assign frame_done   = frame_done_q;
  assign frame_err    = frame_err_q;
  assign frame_count  = frame_count_q;

endmodule

// File: tb/tb_fft_bin_collector.sv
// tb/tb_fft_bin_collector.sv - randomized scoreboard bench for fft_bin_collector
module tb_fft_bin_collector;

  localparam int N = 256;

  logic        CLK_50 = 1'b0;
  logic        reset = 1'b1;
  logic        source_valid = 1'b0;
  logic        source_sop = 1'b0;
  logic        source_eop = 1'b0;
  logic [1:0]  source_error = 2'b00;
  logic [23:0] source_real = '0;
  logic [23:0] source_imag = '0;
  logic [5:0]  source_exp = '0;
  logic        source_ready;
  logic [7:0]  rd_addr = '0;
  logic [15:0] rd_data;
  logic        bank_sel;
  logic        frame_done;
  logic        frame_err;
  logic [15:0] frame_count;

  fft_bin_collector dut (
    .CLK_50       (CLK_50),
    .reset        (reset),
    .source_valid (source_valid),
    .source_sop   (source_sop),
    .source_eop   (source_eop),
    .source_error (source_error),
    .source_real  (source_real),
    .source_imag  (source_imag),
    .source_exp   (source_exp),
    .source_ready (source_ready),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .bank_sel     (bank_sel),
    .frame_done   (frame_done),
    .frame_err    (frame_err),
    .frame_count  (frame_count)
  );

  always #5 CLK_50 = ~CLK_50;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge CLK_50) cyc <= cyc + 1;

  typedef struct {
    bit done;
    int cyc;
    int cnt;
    bit bank;
  } ev_t;

  ev_t ev_q[$];
  int  rd_exp_q[$];
  bit  rd_en = 1'b0;
  bit  rd_en_d = 1'b0;
  always @(posedge CLK_50) rd_en_d <= rd_en;

  int spec_ref[N];
  int fr_re[N];
  int fr_im[N];
  int exp_cnt = 0;
  bit exp_bank = 1'b0;
  bit pending_abandon = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // reference magnitude from the arithmetic rules, using plain integer math
  function automatic int ref_mag(input int re, input int im, input int ex);
    longint a, b, m, v;
    int s;
    a = (re < 0) ? -re : re;
    b = (im < 0) ? -im : im;
    if (a > 8388607) a = 8388607;
    if (b > 8388607) b = 8388607;
    m = (a > b) ? a + b / 2 : b + a / 2;
    s = -ex;
    if (s < 0) s = 0;
    if (s > 15) s = 15;
    v = m;
    for (int k = 0; k < s; k++) v = v * 2;
    v = v / 512;
    if (v > 65535) v = 65535;
    return int'(v);
  endfunction

  function automatic int rand24();
    if ($urandom_range(0, 15) == 0) return -8388608;
    return int'($urandom_range(0, 24'hFFFFFF)) - 8388608;
  endfunction

  function automatic int rand_exp();
    return int'($urandom_range(0, 63)) - 32;
  endfunction

  task automatic push_ev(input bit done, input int c);
    ev_t e;
    e.done = done;
    e.cyc  = c;
    e.cnt  = exp_cnt;
    e.bank = exp_bank;
    ev_q.push_back(e);
  endtask

  // monitor: pops the scoreboard whenever the DUT presents a frame event or read data
  ev_t mon_e;
  always @(negedge CLK_50) begin
    if (!reset) begin
      if (frame_done || frame_err) begin
        if (ev_q.size() == 0) begin
          check("unexpected_frame_event", {frame_done, frame_err}, 0);
        end else begin
          mon_e = ev_q.pop_front();
          check("event_done", frame_done, mon_e.done);
          check("event_err", frame_err, !mon_e.done);
          check("event_cycle", cyc, mon_e.cyc);
          if (mon_e.done) begin
            check("done_frame_count", frame_count, mon_e.cnt);
            check("done_bank_sel", bank_sel, mon_e.bank);
          end
        end
      end
      if (rd_en_d) begin
        if (rd_exp_q.size() == 0) check("read_underflow", 1, 0);
        else check("rd_data", rd_data, rd_exp_q.pop_front());
      end
    end
  end

  task automatic idle();
    @(negedge CLK_50);
    source_valid = 1'b0;
    source_sop   = 1'b0;
    source_eop   = 1'b0;
  endtask

  task automatic beat(input bit sop, input bit eop, input bit err, input int re, input int im,
                      input int ex, input bit gaps);
    if (gaps) begin
      while ($urandom_range(0, 3) == 0) begin
        @(negedge CLK_50);
        source_valid = 1'b0;
      end
    end
    @(negedge CLK_50);
    source_valid = 1'b1;
    source_sop   = sop;
    source_eop   = eop;
    source_error = err ? 2'b01 : 2'b00;
    source_real  = 24'(re);
    source_imag  = 24'(im);
    source_exp   = 6'(ex);
  endtask

  // drives one frame and records its expected outcome in the scoreboard
  task automatic send_frame(input int len, input bit do_eop, input int err_bin, input int ex,
                            input bit gaps);
    for (int i = 0; i < len; i++) begin
      beat(i == 0, do_eop && (i == len - 1), i == err_bin, fr_re[i], fr_im[i],
           (i == 0) ? ex : rand_exp(), gaps);
      if (i == 0 && pending_abandon) begin
        push_ev(1'b0, cyc + 2);
        pending_abandon = 1'b0;
      end
    end
    if (len == N && do_eop && err_bin < 0) begin
      exp_cnt  = (exp_cnt + 1) % 65536;
      exp_bank = !exp_bank;
      push_ev(1'b1, cyc + 3);
      for (int i = 0; i < N; i++) spec_ref[i] = ref_mag(fr_re[i], fr_im[i], ex);
    end else if (do_eop) begin
      push_ev(1'b0, cyc + 3);
    end else if (len == N) begin
      push_ev(1'b0, cyc + 2);
    end else begin
      pending_abandon = 1'b1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    idle();
    while (ev_q.size() != 0 && n < 40) begin
      @(negedge CLK_50);
      n++;
    end
    check("event_drain_timeout", ev_q.size(), 0);
    ev_q.delete();
    check("bank_sel", bank_sel, exp_bank);
    check("frame_count", frame_count, exp_cnt);
  endtask

  task automatic rd(input int a, input int e);
    @(negedge CLK_50);
    rd_addr = 8'(a);
    rd_en   = 1'b1;
    rd_exp_q.push_back(e);
  endtask

  task automatic rd_done();
    @(negedge CLK_50);
    rd_en = 1'b0;
    @(negedge CLK_50);
  endtask

  task automatic rd_random(input int n);
    int a;
    for (int k = 0; k < n; k++) begin
      a = int'($urandom_range(0, N - 1));
      rd(a, spec_ref[a]);
    end
    rd_done();
  endtask

  task automatic clear_frame();
    for (int i = 0; i < N; i++) begin
      fr_re[i] = 0;
      fr_im[i] = 0;
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++) begin
      fr_re[i] = rand24();
      fr_im[i] = rand24();
    end
  endtask

  task automatic check_reset_vals();
    check("rst_source_ready", source_ready, 0);
    check("rst_bank_sel", bank_sel, 0);
    check("rst_frame_count", frame_count, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_rd_data", rd_data, 0);
  endtask

  task automatic release_reset();
    @(negedge CLK_50);
    reset = 1'b0;
    repeat (2) @(negedge CLK_50);
    check("source_ready_up", source_ready, 1);
  endtask

  initial begin
    repeat (3) @(negedge CLK_50);
    check_reset_vals();
    release_reset();

    // clean frame, exp 0: scaled bin and the saturated most-negative code
    clear_frame();
    fr_re[5] = 'h100000;
    fr_im[5] = 'h080000;
    fr_re[9] = -'h800000;
    send_frame(N, 1'b1, -1, 0, 1'b1);
    drain();
    check("first_commit_count", frame_count, 1);
    check("first_commit_bank", bank_sel, 1);
    rd(5, 'h0A00);
    rd(9, 'h3FFF);
    rd(0, 0);
    rd(6, 0);
    rd(255, 0);
    rd_done();

    // same bin with exp -2
    clear_frame();
    fr_re[5] = 'h100000;
    fr_im[5] = 'h080000;
    send_frame(N, 1'b1, -1, -2, 1'b1);
    drain();
    rd(5, 'h2800);
    rd(4, 0);
    rd_done();

    // full-scale bin with exp -4 saturates, rest random
    fill_random();
    fr_re[7] = 'h7FFFFF;
    fr_im[7] = 'h7FFFFF;
    send_frame(N, 1'b1, -1, -4, 1'b1);
    drain();
    rd(7, 'hFFFF);
    rd_random(6);

    // random frames with random exponents
    for (int f = 0; f < 2; f++) begin
      fill_random();
      send_frame(N, 1'b1, -1, rand_exp(), 1'b1);
      drain();
      rd_random(10);
    end

    // early eop at bin 100: dropped, previous spectrum intact
    fill_random();
    send_frame(101, 1'b1, -1, 0, 1'b1);
    drain();
    rd_random(6);

    // error flag on bin 40: dropped
    fill_random();
    send_frame(N, 1'b1, 40, 0, 1'b1);
    drain();
    rd_random(6);

    // second sop mid-frame: abandoned frame errors, restarted frame commits
    fill_random();
    send_frame(60, 1'b0, -1, 0, 1'b1);
    fill_random();
    send_frame(N, 1'b1, -1, rand_exp(), 1'b1);
    drain();
    rd_random(8);

    // missing eop on the last bin
    fill_random();
    send_frame(N, 1'b0, -1, 0, 1'b1);
    drain();
    rd_random(4);

    // back-to-back frames with no idle cycle between eop and sop
    fill_random();
    send_frame(N, 1'b1, -1, rand_exp(), 1'b0);
    clear_frame();
    for (int i = 0; i < N; i++) fr_re[i] = 'h010000;
    send_frame(N, 1'b1, -1, 0, 1'b0);
    drain();
    check("b2b_bank_back_to_0", bank_sel, 0);
    rd(0, 'h0080);
    rd(128, 'h0080);
    rd(255, 'h0080);
    rd_done();

    // reset in the middle of a frame, then a clean frame commits from scratch
    fill_random();
    send_frame(128, 1'b0, -1, 0, 1'b1);
    @(negedge CLK_50);
    reset        = 1'b1;
    source_valid = 1'b0;
    source_sop   = 1'b0;
    source_eop   = 1'b0;
    pending_abandon = 1'b0;
    exp_cnt  = 0;
    exp_bank = 1'b0;
    ev_q.delete();
    repeat (3) @(negedge CLK_50);
    check_reset_vals();
    release_reset();
    fill_random();
    send_frame(N, 1'b1, -1, rand_exp(), 1'b1);
    drain();
    check("post_reset_count", frame_count, 1);
    rd_random(8);

    drain();
    check("read_queue_empty", rd_exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
